i2c_init_sequencer: RTL and testbench
=====================================

Name: i2c_init_sequencer

Overview:
Upstream command source for the byte-oriented I2C master. At power-up or on request, it walks a synchronous table of (7-bit device address, data byte) entries. For each entry it issues one single-byte write transaction to the master, then waits for the master's done or err. On error or timeout it retries, with a bounded retry count. Used to configure attached peripherals (sensors, displays) without a CPU.

Parameters:
AW, 5, table address width; table holds up to 2**AW entries
MAX_RETRY, 3, extra attempts per entry after the first failure (0..15)
GAP_CYCLES, 16, idle clk cycles between transactions (>=1)
TIMEOUT_CYCLES, 4096, clk cycles allowed for m_done/m_err after m_start falls (>=2)
START_CYCLES, 2, width of m_start pulse in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
go  in  1  level-sampled; rising edge (registered) starts a sequence when idle
busy  out  1  high from accepted go until all_done or fail
all_done  out  1  sticky; end marker reached with every entry acknowledged
fail  out  1  sticky; an entry exhausted its retries
fail_idx  out  AW  table index of the failing entry (valid when fail=1)
tbl_addr  out  AW  table read address
tbl_data  in  16  table word, 1-cycle read latency: [15] end marker, [14:8] 7-bit device addr, [7:0] data byte
m_addr  out  8  to master addr: {dev_addr, 1'b0} (write only)
m_data  out  8  to master data
m_num_bytes  out  6  constant 6'd1
m_start  out  1  to master start
m_done  in  1  from master done
m_err  in  1  from master err

Behaviour:
- Reset (async): state IDLE, busy=0, all_done=0, fail=0, fail_idx=0, tbl_addr=0, m_addr=0, m_data=0, m_start=0, all counters 0. The edge-detect registers for go/m_done/m_err clear to 0.
- m_done and m_err pass through a 2-flop synchronizer plus a previous-value flop. A success event is a rising edge of synchronized m_done; an error event is a rising edge of synchronized m_err.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, GAP, FINISH, FAIL.
- IDLE: a go rising edge clears all_done/fail, sets busy=1, tbl_addr=0, retry=0, and moves to FETCH. A go edge in any state other than IDLE is ignored.
- FETCH: 1 cycle, covering ROM latency. Then LATCH.
- LATCH: if tbl_data[15]=1, go to FINISH. Otherwise load m_addr={tbl_data[14:8],0} and m_data=tbl_data[7:0], then go to ISSUE. If tbl_addr=2**AW-1 and no end marker has been seen, treat the next index as an end marker: after this entry succeeds, go to FINISH with no wrap.
- ISSUE: m_start=1 for exactly START_CYCLES cycles, and m_addr/m_data are stable the whole time. Then m_start=0, the timeout counter clears, and the block moves to WAIT.
- WAIT: the timeout counter increments each cycle.
  - Success event: retry=0, tbl_addr+1, go to GAP (or FINISH on last index).
  - Error event or counter reaching TIMEOUT_CYCLES-1: if retry<MAX_RETRY, retry+1 and go to GAP without advancing tbl_addr. Otherwise fail_idx=tbl_addr and go to FAIL.
  - Success and error in the same cycle count as an error.
- GAP: wait GAP_CYCLES cycles, which lets the master finish STOP and return to idle. Then FETCH. m_addr/m_data hold their values.
- FINISH: all_done=1, busy=0, return to IDLE.
- FAIL: fail=1, busy=0, return to IDLE.
- all_done and fail stay set until the next accepted go or reset; the two are never both 1.
- Minimum per-entry latency from FETCH to next FETCH: 2 + START_CYCLES + (master time) + GAP_CYCLES.
- Reset asserted mid-transaction drops m_start immediately. The master is not aborted by this block.

Test Plan:
- Table {0x3C/0xAE, 0x3C/0xAF, end}, master model acks every byte -> two m_start pulses of 2 cycles with m_addr=0x78, m_data=0xAE then 0xAF. all_done=1 and busy=0 after the end marker; fail=0.
- Entry 0 gets m_err on the 1st attempt and m_done on the 2nd -> exactly 2 starts with identical m_addr/m_data, the 2nd start at least GAP_CYCLES after the error, then all_done=1.
- Entry 1 always returns m_err with MAX_RETRY=3 -> 4 starts for entry 1, then fail=1, fail_idx=1, all_done=0. Entry 2 is never issued.
- Master model never responds, TIMEOUT_CYCLES=64 -> each attempt waits exactly 64 cycles, giving 4 attempts, then fail=1, fail_idx=0.
- Table with no end marker across all 32 entries, all acked -> 32 starts, tbl_addr does not wrap, all_done=1.
- rst asserted during ISSUE -> m_start=0 and busy=0 in the same cycle. A go after reset restarts from index 0. A go pulsed while busy does not restart the sequence.

Source files
------------

// File: rtl/i2c_init_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// i2c_init_sequencer
//
// Walks a synchronous table of (7-bit device address, data byte) entries
// after power-up or on request. For each entry it issues one single-byte
// write to the byte-oriented I2C master and then waits for done or err.
// Errors and timeouts are retried a bounded number of times. The sequence
// ends at an end-marker word or after the last table slot.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   go            level input; a registered rising edge starts a sequence
//   busy          high while a sequence is running
//   all_done      sticky: every entry up to the end marker was acknowledged
//   fail          sticky: an entry ran out of retries
//   fail_idx      table index of the failing entry (valid while fail=1)
//   tbl_addr      table read address (1-cycle read latency)
//   tbl_data      {end_marker, dev_addr[6:0], data[7:0]}
//   m_addr        {dev_addr, 1'b0} to the master (always a write)
//   m_data        data byte to the master
//   m_num_bytes   constant 1
//   m_start       start strobe, START_CYCLES wide
//   m_done/m_err  completion status from the master (resynchronised here)
// ----------------------------------------------------------------------------
module i2c_init_sequencer #(
    parameter int AW             = 5,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int START_CYCLES   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    output logic          busy,
    output logic          all_done,
    output logic          fail,
    output logic [AW-1:0] fail_idx,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    output logic [7:0]    m_addr,
    output logic [7:0]    m_data,
    output logic [5:0]    m_num_bytes,
    output logic          m_start,
    input  logic          m_done,
    input  logic          m_err
);

    // One shared cycle counter serves ISSUE, WAIT and GAP; size it for the
    // longest of the three intervals.
    localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES)
                        ? ((TIMEOUT_CYCLES > START_CYCLES) ? TIMEOUT_CYCLES : START_CYCLES)
                        : ((GAP_CYCLES > START_CYCLES) ? GAP_CYCLES : START_CYCLES);
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_FINISH,
        S_FAIL
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_m_start;

    logic            r_go_s;
    logic            r_go_prev;
    logic            r_done_s1, r_done_s2, r_done_prev;
    logic            r_err_s1,  r_err_s2,  r_err_prev;

    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_retry;
    logic            r_last;
    logic            r_busy;
    logic            r_all_done;
    logic            r_fail;
    logic [AW-1:0]   r_fail_idx;
    logic [AW-1:0]   r_tbl_addr;
    logic [7:0]      r_m_addr;
    logic [7:0]      r_m_data;

    logic            w_go_rise;
    logic            w_done_evt;
    logic            w_err_evt;
    logic            w_timeout;
    logic            w_retry_ok;
    logic            w_attempt_bad;
    logic            w_attempt_ok;

    // ------------------------------------------------------------------
    // Input conditioning: go edge detect, m_done/m_err 2-flop synchronisers
    // followed by a previous-value flop for rising-edge events.
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values, which is what makes the sync chains work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_go_s      <= 1'b0;
            r_go_prev   <= 1'b0;
            r_done_s1   <= 1'b0;
            r_done_s2   <= 1'b0;
            r_done_prev <= 1'b0;
            r_err_s1    <= 1'b0;
            r_err_s2    <= 1'b0;
            r_err_prev  <= 1'b0;
        end else begin
            r_go_s      <= go;
            r_go_prev   <= r_go_s;
            r_done_s1   <= m_done;
            r_done_s2   <= r_done_s1;
            r_done_prev <= r_done_s2;
            r_err_s1    <= m_err;
            r_err_s2    <= r_err_s1;
            r_err_prev  <= r_err_s2;
        end
    end

    assign w_go_rise  = r_go_s & ~r_go_prev;
    assign w_done_evt = r_done_s2 & ~r_done_prev;
    assign w_err_evt  = r_err_s2 & ~r_err_prev;
    assign w_timeout  = (r_cnt == TO_LAST);
    assign w_retry_ok = (r_retry < RETRY_MAX);

    // An error wins over a simultaneous done; a done that lands on the
    // timeout cycle still counts as a completed transaction.
    assign w_attempt_bad = w_err_evt | (w_timeout & ~w_done_evt);
    assign w_attempt_ok  = w_done_evt & ~w_err_evt;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // FSM next state and decoded outputs
    // ------------------------------------------------------------------
    // NOTE: defaults are assigned before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_m_start    = 1'b0;
        case (r_state)
            S_IDLE:   if (w_go_rise) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_LATCH;
            S_LATCH:  w_next_state = tbl_data[15] ? S_FINISH : S_ISSUE;
            S_ISSUE: begin
                w_m_start = 1'b1;
                if (r_cnt == START_LAST) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_attempt_bad)     w_next_state = w_retry_ok ? S_GAP : S_FAIL;
                else if (w_attempt_ok) w_next_state = r_last ? S_FINISH : S_GAP;
            end
            S_GAP:    if (r_cnt == GAP_LAST) w_next_state = S_FETCH;
            S_FINISH: w_next_state = S_IDLE;
            S_FAIL:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counter, table pointer, retry bookkeeping, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_retry    <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_all_done <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_idx <= '0;
            r_tbl_addr <= '0;
            r_m_addr   <= '0;
            r_m_data   <= '0;
        end else begin
            // Counter restarts on every state change so each timed state
            // sees 0 on its first cycle.
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (r_state == S_ISSUE || r_state == S_WAIT || r_state == S_GAP)
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_go_rise) begin
                        r_busy     <= 1'b1;
                        r_all_done <= 1'b0;
                        r_fail     <= 1'b0;
                        r_tbl_addr <= '0;
                        r_retry    <= '0;
                        r_last     <= 1'b0;
                    end
                end
                S_LATCH: begin
                    if (!tbl_data[15]) begin
                        r_m_addr <= {tbl_data[14:8], 1'b0};
                        r_m_data <= tbl_data[7:0];
                        // The slot after the top index is treated as an end
                        // marker, so the pointer never wraps.
                        r_last   <= &r_tbl_addr;
                    end
                end
                S_WAIT: begin
                    if (w_attempt_bad) begin
                        if (w_retry_ok) r_retry    <= r_retry + 4'd1;
                        else            r_fail_idx <= r_tbl_addr;
                    end else if (w_attempt_ok) begin
                        r_retry <= '0;
                        if (!r_last) r_tbl_addr <= r_tbl_addr + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_all_done <= 1'b1;
                    r_busy     <= 1'b0;
                end
                S_FAIL: begin
                    r_fail <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign all_done    = r_all_done;
    assign fail        = r_fail;
    assign fail_idx    = r_fail_idx;
    assign tbl_addr    = r_tbl_addr;
    assign m_addr      = r_m_addr;
    assign m_data      = r_m_data;
    assign m_num_bytes = 6'd1;
    assign m_start     = w_m_start;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_i2c_init_sequencer
//
// Directed bench with a behavioural table ROM and I2C master model. Each
// expected master transaction is queued when a test is set up; the master
// model pops and compares it whenever the DUT raises m_start.
// ----------------------------------------------------------------------------
module tb_i2c_init_sequencer;

    localparam int AW      = 5;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 64;

    localparam logic [1:0] R_DONE = 2'd0;
    localparam logic [1:0] R_ERR  = 2'd1;
    localparam logic [1:0] R_NONE = 2'd2;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          busy;
    logic          all_done;
    logic          fail;
    logic [AW-1:0] fail_idx;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_data;
    logic [7:0]    m_addr;
    logic [7:0]    m_data;
    logic [5:0]    m_num_bytes;
    logic          m_start;
    logic          m_done;
    logic          m_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   start_no = 0;
    logic mon_chk  = 1'b1;

    logic [15:0] rom [0:31];
    logic [1:0]  resp [0:63];
    int          rise_cyc [0:63];
    int          fall_cyc [0:63];
    int          err_cyc  [0:63];
    exp_t        exp_q [$];

    i2c_init_sequencer #(
        .AW(AW), .MAX_RETRY(3), .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TIMEOUT), .START_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .all_done(all_done),
        .fail(fail), .fail_idx(fail_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .m_addr(m_addr), .m_data(m_data), .m_num_bytes(m_num_bytes),
        .m_start(m_start), .m_done(m_done), .m_err(m_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h8000;
    endtask

    task automatic set_resp_all(input logic [1:0] r);
        for (int i = 0; i < 64; i++) resp[i] = r;
    endtask

    task automatic put_entry(input int idx, input logic [6:0] dev, input logic [7:0] dat);
        rom[idx] = {1'b0, dev, dat};
    endtask

    task automatic expect_start(input logic [6:0] dev, input logic [7:0] dat);
        exp_t e;
        e.addr = {dev, 1'b0};
        e.data = dat;
        exp_q.push_back(e);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (busy === lvl) seen = 1'b1;
        end
        check(tag, seen, 1);
    endtask

    task automatic run_seq(input int budget, input string tag);
        go = 1'b1;
        wait_busy(1'b1, 20, {tag, "_busy_rise"});
        check({tag, "_sticky_clear"}, {all_done, fail}, 0);
        go = 1'b0;
        wait_busy(1'b0, budget, {tag, "_busy_fall"});
        repeat (2) @(negedge clk);
    endtask

    task automatic new_test();
        start_no = 0;
        exp_q.delete();
        clear_rom();
        set_resp_all(R_DONE);
    endtask

    // Master model: measures each m_start pulse, checks it against the
    // scoreboard, then answers with done, err or nothing.
    initial begin : master_model
        int         idx;
        int         width;
        logic [7:0] s_a, s_d;
        logic       stable;
        logic       ended;
        logic [1:0] r;
        exp_t       e;
        m_done = 1'b0;
        m_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (m_start === 1'b1) begin
                idx = start_no;
                start_no++;
                if (idx < 64) rise_cyc[idx] = cyc;
                s_a = m_addr; s_d = m_data; width = 1; stable = 1'b1; ended = 1'b0;
                while (!ended) begin
                    @(negedge clk);
                    if (m_start !== 1'b1 || width >= 16) ended = 1'b1;
                    else begin
                        width++;
                        if (m_addr !== s_a || m_data !== s_d) stable = 1'b0;
                    end
                end
                if (idx < 64) fall_cyc[idx] = cyc;
                if (mon_chk) begin
                    check("sb_start_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_m_addr", s_a, e.addr);
                        check("sb_m_data", s_d, e.data);
                    end
                    check("start_width", width, 2);
                    check("start_addr_data_stable", stable, 1);
                end
                r = (idx < 64) ? resp[idx] : R_DONE;
                if (r != R_NONE) begin
                    repeat (4) @(negedge clk);
                    if (r == R_ERR) begin
                        m_err = 1'b1;
                        if (idx < 64) err_cyc[idx] = cyc;
                    end else begin
                        m_done = 1'b1;
                    end
                    repeat (3) @(negedge clk);
                    m_err  = 1'b0;
                    m_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   n;
        logic seen;

        rst = 1'b1;
        go  = 1'b0;
        new_test();
        repeat (3) @(negedge clk);
        check("rst_m_start_during_rst", m_start, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_all_done", all_done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_start", m_start, 0);
        check("m_num_bytes", m_num_bytes, 1);

        // T1: two entries, all acknowledged
        new_test();
        put_entry(0, 7'h3C, 8'hAE);
        put_entry(1, 7'h3C, 8'hAF);
        expect_start(7'h3C, 8'hAE);
        expect_start(7'h3C, 8'hAF);
        run_seq(500, "t1");
        check("t1_all_done", all_done, 1);
        check("t1_fail", fail, 0);
        check("t1_starts", start_no, 2);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_m_data_hold", m_data, 8'hAF);

        // T2: entry 0 errors once, then succeeds
        new_test();
        put_entry(0, 7'h50, 8'h11);
        put_entry(1, 7'h51, 8'h22);
        resp[0] = R_ERR;
        expect_start(7'h50, 8'h11);
        expect_start(7'h50, 8'h11);
        expect_start(7'h51, 8'h22);
        run_seq(600, "t2");
        check("t2_all_done", all_done, 1);
        check("t2_fail", fail, 0);
        check("t2_starts", start_no, 3);
        check("t2_sb_empty", exp_q.size(), 0);
        check("t2_retry_gap_ge", (rise_cyc[1] - err_cyc[0]) >= GAP, 1);

        // T3: entry 1 always errors, retries exhaust
        new_test();
        put_entry(0, 7'h10, 8'hA0);
        put_entry(1, 7'h11, 8'hA1);
        put_entry(2, 7'h12, 8'hA2);
        for (int i = 1; i <= 4; i++) resp[i] = R_ERR;
        expect_start(7'h10, 8'hA0);
        for (int i = 0; i < 4; i++) expect_start(7'h11, 8'hA1);
        run_seq(1000, "t3");
        check("t3_fail", fail, 1);
        check("t3_fail_idx", fail_idx, 1);
        check("t3_all_done", all_done, 0);
        check("t3_starts", start_no, 5);
        check("t3_sb_empty", exp_q.size(), 0);

        // T4: master never answers, every attempt times out
        new_test();
        put_entry(0, 7'h22, 8'h5A);
        put_entry(1, 7'h23, 8'h5B);
        set_resp_all(R_NONE);
        for (int i = 0; i < 4; i++) expect_start(7'h22, 8'h5A);
        run_seq(2000, "t4");
        check("t4_fail", fail, 1);
        check("t4_fail_idx", fail_idx, 0);
        check("t4_all_done", all_done, 0);
        check("t4_starts", start_no, 4);
        check("t4_sb_empty", exp_q.size(), 0);
        for (int i = 1; i < 4; i++)
            check("t4_timeout_spacing", rise_cyc[i] - fall_cyc[i-1], TIMEOUT + GAP + 2);

        // T5: full table, no end marker
        new_test();
        for (int i = 0; i < 32; i++) begin
            put_entry(i, 7'(7'h40 + i), 8'(8'hC0 ^ i));
            expect_start(7'(7'h40 + i), 8'(8'hC0 ^ i));
        end
        run_seq(3000, "t5");
        check("t5_all_done", all_done, 1);
        check("t5_fail", fail, 0);
        check("t5_starts", start_no, 32);
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_tbl_addr_no_wrap", tbl_addr, 31);

        // T6: reset during ISSUE of entry 1, then restart; go while busy ignored
        new_test();
        mon_chk = 1'b0;
        put_entry(0, 7'h20, 8'h01);
        put_entry(1, 7'h21, 8'h02);
        resp[1] = R_NONE;
        go = 1'b1;
        wait_busy(1'b1, 20, "t6_busy_rise");
        go = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (m_start === 1'b1 && m_data === 8'h02) seen = 1'b1;
        end
        check("t6_reached_issue", seen, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_m_start", m_start, 0);
        check("t6_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        start_no = 0;
        set_resp_all(R_DONE);
        mon_chk = 1'b1;
        expect_start(7'h20, 8'h01);
        expect_start(7'h21, 8'h02);
        go = 1'b1;
        wait_busy(1'b1, 20, "t6b_busy_rise");
        go = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (m_start === 1'b1) seen = 1'b1;
        end
        check("t6b_first_start", seen, 1);
        go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        wait_busy(1'b0, 600, "t6b_busy_fall");
        repeat (2) @(negedge clk);
        check("t6b_all_done", all_done, 1);
        check("t6b_fail", fail, 0);
        check("t6b_starts", start_no, 2);
        check("t6b_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
